pipelined_controller: RTL and testbench
=======================================

Name: pipelined_controller

Overview:
Next-generation control unit for the 5-stage MIPS pipeline. It replaces single-cycle decode with a decode block plus ID/EX, EX/MEM and MEM/WB control pipeline registers. It also adds load-use stall detection and taken-branch flush. It sits beside the datapath, takes the IF/ID instruction and the EX-stage ALU Zero flag, and drives per-stage control, PC/IF-ID enables and the flush.

Parameters:
REG_ADDR_W, 5, register-index width (destination/source fields)
ALUOP_W, 2, ALUOp bundle width; must be >= 2, upper bits zero-extended
STAT_W, 16, width of the saturating stall/flush counters (optional feature)

Ports:
Clk  in  1  clock, all state on rising edge
Rst  in  1  synchronous active-high reset
Instruction  in  32  IF/ID instruction (opcode [31:26], rs [25:21], rt [20:16], rd [15:11])
Zero  in  1  ALU zero flag for the instruction currently in EX
ExRegDst, ExALUSrc, ExBranch  out  1 each  EX-stage control
ExALUOp  out  ALUOP_W  EX-stage ALU operation class
ExWriteReg  out  REG_ADDR_W  destination register of the EX instruction
MemMemRead, MemMemWrite  out  1 each  MEM-stage control
WbMemtoReg, WbRegWrite  out  1 each  WB-stage control
WbWriteReg  out  REG_ADDR_W  destination register of the WB instruction
PCSrc  out  1  select branch target; combinational = ExBranch & Zero
PCWrite, IfIdWrite  out  1 each  PC / IF-ID register enables
IfIdFlush  out  1  zero IF/ID on next edge
StallCount, FlushCount  out  STAT_W each  performance counters

Behaviour:
- Decode (combinational, ID), by opcode:
  - 000000 R-type: RegDst=1, ALUOp=10, RegWrite=1.
  - 100011 lw: ALUSrc=1, MemRead=1, MemtoReg=1, RegWrite=1, ALUOp=00.
  - 101011 sw: ALUSrc=1, MemWrite=1, ALUOp=00.
  - 000100 beq: Branch=1, ALUOp=01.
  - 001000 addi: ALUSrc=1, RegWrite=1, ALUOp=00.
  - Any other opcode: all-zero bundle (NOP).
- Destination = RegDst ? rd : rt. If destination == 0, RegWrite is forced 0 (so instruction 0x00000000 is a true NOP).
- Pipeline: bundle enters ID/EX on the edge. Ex* outputs are valid 1 cycle after ID, Mem* after 2, Wb* after 3. MEM and WB registers always advance.
- Load-use stall, all conditions required:
  - ID/EX MemRead=1 and ID/EX dest != 0, and
  - dest == IF/ID rs, or dest == IF/ID rt when the ID instruction reads rt (R-type, sw, beq).
  - Response: PCWrite=0, IfIdWrite=0, zero bundle into ID/EX on the next edge. Exactly one bubble per load-use pair.
- Taken branch: when ExBranch & Zero, PCSrc=1 and IfIdFlush=1 in the same cycle; ID/EX loads a zero bundle on the next edge. PCWrite=1, IfIdWrite=1.
- Priority: taken branch over stall. A stall cannot coincide with a taken branch, because the EX instruction cannot be both lw and beq; the priority is still implemented explicitly.
- Not-taken branch (Zero=0): no flush, no bubble.
- Reset: all pipeline registers and counters clear to 0, giving Ex*/Mem*/Wb* = 0, PCSrc=0, IfIdFlush=0, PCWrite=1, IfIdWrite=1. Reset mid-operation discards every in-flight bundle on that edge, with no partial writeback.

Optional Feature:
Macro CTRL_PERF_CNT_EN.
- Defined: StallCount increments on every stall cycle; FlushCount increments on every taken-branch cycle. Both saturate at all-ones and clear on Rst.
- Undefined: both ports are tied to 0 and no counter flops are synthesised.

Decomposition:
- Package ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI);
  - ALUOp encodings (ALU_ADD=00, ALU_SUB=01, ALU_FUNCT=10);
  - a ctrl_bundle_t struct with fields RegDst, ALUSrc, Branch, ALUOp, MemRead, MemWrite, MemtoReg, RegWrite, WriteReg.
- One sub-module, hazard_unit: combinational stall and flush detection. The decoder and the pipeline registers stay in the top module.

Test Plan:
- add $3,$1,$2 (0x00221820): 1 cycle later ExRegDst=1, ExALUOp=10, ExWriteReg=3; 3 cycles later WbRegWrite=1, WbWriteReg=3.
- lw $1,0($0) followed by add $2,$1,$1:
  - cycle after lw enters EX: PCWrite=0, IfIdWrite=0;
  - next cycle: Ex* all zero (bubble), then the add appears on Ex*;
  - StallCount=1.
- beq in EX with Zero=1: PCSrc=1 and IfIdFlush=1 that cycle; next cycle Ex* all zero; FlushCount=1. Repeat with Zero=0: PCSrc=0, no bubble.
- Instruction 0x00000000 and add $0,$1,$2: WbRegWrite stays 0. Unknown opcode 111111: all outputs 0.
- Rst=1 asserted with lw/sw/add in flight: after one edge all stage outputs and counters are 0, PCWrite=1. Feeding a new add afterwards flows normally.
- Force 2^STAT_W+3 stalls with CTRL_PERF_CNT_EN defined: StallCount holds at all-ones. With the macro undefined, StallCount stays 0.

Source files
------------

// File: rtl/pipelined_controller_pkg.sv
// Shared types and encodings for the pipelined MIPS control unit (package ctrl_pkg).
package ctrl_pkg;

  // Register-index width implied by the MIPS instruction format.
  localparam int unsigned REG_W = 5;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_BEQ   = 6'b000100,
    OP_ADDI  = 6'b001000,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  // Control bundle carried down the pipeline; an all-zero bundle is a bubble.
  typedef struct packed {
    logic             RegDst;
    logic             ALUSrc;
    logic             Branch;
    alu_op_e          ALUOp;
    logic             MemRead;
    logic             MemWrite;
    logic             MemtoReg;
    logic             RegWrite;
    logic [REG_W-1:0] WriteReg;
  } ctrl_bundle_t;

endpackage

// File: rtl/pipelined_controller_if.sv
// Control-unit bus: IF/ID instruction and Zero in, per-stage control and enables out.
interface pipelined_controller_if #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned ALUOP_W    = 2,
  parameter int unsigned STAT_W     = 16
) ();

  logic [31:0]           Instruction;
  logic                  Zero;
  logic                  ExRegDst;
  logic                  ExALUSrc;
  logic                  ExBranch;
  logic [ALUOP_W-1:0]    ExALUOp;
  logic [REG_ADDR_W-1:0] ExWriteReg;
  logic                  MemMemRead;
  logic                  MemMemWrite;
  logic                  WbMemtoReg;
  logic                  WbRegWrite;
  logic [REG_ADDR_W-1:0] WbWriteReg;
  logic                  PCSrc;
  logic                  PCWrite;
  logic                  IfIdWrite;
  logic                  IfIdFlush;
  logic [STAT_W-1:0]     StallCount;
  logic [STAT_W-1:0]     FlushCount;

  // Datapath side.
  modport master (
    output Instruction, Zero,
    input  ExRegDst, ExALUSrc, ExBranch, ExALUOp, ExWriteReg,
    input  MemMemRead, MemMemWrite,
    input  WbMemtoReg, WbRegWrite, WbWriteReg,
    input  PCSrc, PCWrite, IfIdWrite, IfIdFlush,
    input  StallCount, FlushCount
  );

  // Controller side.
  modport slave (
    input  Instruction, Zero,
    output ExRegDst, ExALUSrc, ExBranch, ExALUOp, ExWriteReg,
    output MemMemRead, MemMemWrite,
    output WbMemtoReg, WbRegWrite, WbWriteReg,
    output PCSrc, PCWrite, IfIdWrite, IfIdFlush,
    output StallCount, FlushCount
  );

endinterface

// File: rtl/pipelined_controller_hazard_unit.sv
// Combinational load-use stall and taken-branch flush detection.
module hazard_unit
  import ctrl_pkg::*;
(
  input  logic             ex_mem_read_i,
  input  logic [REG_W-1:0] ex_dest_i,
  input  logic             ex_branch_i,
  input  logic             zero_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_reads_rt_i,
  output logic             stall_o,
  output logic             flush_o
);

  logic load_use;

  // A taken branch wins over a load-use stall.
  always_comb begin
    load_use = ex_mem_read_i && (ex_dest_i != '0) &&
               ((ex_dest_i == id_rs_i) || (id_reads_rt_i && (ex_dest_i == id_rt_i)));
    flush_o  = ex_branch_i & zero_i;
    stall_o  = load_use & ~flush_o;
  end

endmodule

// File: rtl/pipelined_controller.sv
// Pipelined MIPS control unit: ID decode, ID/EX, EX/MEM, MEM/WB control registers,
// load-use stall and taken-branch flush. Optional counters: CTRL_PERF_CNT_EN.
module pipelined_controller
  import ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned ALUOP_W    = 2,
  parameter int unsigned STAT_W     = 16
) (
  input logic                  Clk,
  input logic                  Rst,
  pipelined_controller_if.slave bus
);

  logic [5:0]       opcode;
  logic [REG_W-1:0] id_rs, id_rt, id_rd;
  logic             id_reads_rt;
  logic             id_known;
  ctrl_bundle_t     id_bundle;
  ctrl_bundle_t     idex_d, idex_q, exmem_q, memwb_q;
  logic             stall, flush;
  logic             unused_imm;

  assign opcode     = bus.Instruction[31:26];
  assign id_rs      = bus.Instruction[25:21];
  assign id_rt      = bus.Instruction[20:16];
  assign id_rd      = bus.Instruction[15:11];
  assign unused_imm = ^bus.Instruction[10:0];

  // ID-stage decode of the opcode into a control bundle.
  always_comb begin
    id_bundle   = '0;
    id_reads_rt = 1'b0;
    id_known    = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        id_bundle.RegDst   = 1'b1;
        id_bundle.ALUOp    = ALU_FUNCT;
        id_bundle.RegWrite = 1'b1;
        id_reads_rt        = 1'b1;
      end
      OP_LW: begin
        id_bundle.ALUSrc   = 1'b1;
        id_bundle.MemRead  = 1'b1;
        id_bundle.MemtoReg = 1'b1;
        id_bundle.RegWrite = 1'b1;
        id_bundle.ALUOp    = ALU_ADD;
      end
      OP_SW: begin
        id_bundle.ALUSrc   = 1'b1;
        id_bundle.MemWrite = 1'b1;
        id_bundle.ALUOp    = ALU_ADD;
        id_reads_rt        = 1'b1;
      end
      OP_BEQ: begin
        id_bundle.Branch   = 1'b1;
        id_bundle.ALUOp    = ALU_SUB;
        id_reads_rt        = 1'b1;
      end
      OP_ADDI: begin
        id_bundle.ALUSrc   = 1'b1;
        id_bundle.RegWrite = 1'b1;
        id_bundle.ALUOp    = ALU_ADD;
      end
      default: id_known = 1'b0;
    endcase
    // Unknown opcodes keep a fully zero bundle, destination included.
    if (id_known) begin
      id_bundle.WriteReg = id_bundle.RegDst ? id_rd : id_rt;
      if (id_bundle.WriteReg == '0) id_bundle.RegWrite = 1'b0;
    end
  end

  hazard_unit u_hazard (
    .ex_mem_read_i (idex_q.MemRead),
    .ex_dest_i     (idex_q.WriteReg),
    .ex_branch_i   (idex_q.Branch),
    .zero_i        (bus.Zero),
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .id_reads_rt_i (id_reads_rt),
    .stall_o       (stall),
    .flush_o       (flush)
  );

  // Bubble into ID/EX on a stall or a taken branch.
  always_comb begin
    idex_d = id_bundle;
    if (flush || stall) idex_d = '0;
  end

  // Control pipeline registers; MEM and WB always advance.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= idex_q;
      memwb_q <= exmem_q;
    end
  end

  assign bus.ExRegDst    = idex_q.RegDst;
  assign bus.ExALUSrc    = idex_q.ALUSrc;
  assign bus.ExBranch    = idex_q.Branch;
  assign bus.ExALUOp     = ALUOP_W'(idex_q.ALUOp);
  assign bus.ExWriteReg  = REG_ADDR_W'(idex_q.WriteReg);
  assign bus.MemMemRead  = exmem_q.MemRead;
  assign bus.MemMemWrite = exmem_q.MemWrite;
  assign bus.WbMemtoReg  = memwb_q.MemtoReg;
  assign bus.WbRegWrite  = memwb_q.RegWrite;
  assign bus.WbWriteReg  = REG_ADDR_W'(memwb_q.WriteReg);
  assign bus.PCSrc       = flush;
  assign bus.IfIdFlush   = flush;
  assign bus.PCWrite     = ~stall;
  assign bus.IfIdWrite   = ~stall;

`ifdef CTRL_PERF_CNT_EN
  logic [STAT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Saturating stall / taken-branch counters.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + STAT_W'(1);
      if (flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + STAT_W'(1);
    end
  end

  assign bus.StallCount = stall_cnt_q;
  assign bus.FlushCount = flush_cnt_q;
`else
  assign bus.StallCount = '0;
  assign bus.FlushCount = '0;
`endif

endmodule

// File: tb/tb_pipelined_controller.sv
// Bench for pipelined_controller: decode table, hazard sequences, random vs. model.
module tb_pipelined_controller;

  localparam int unsigned TB_STAT_W = 4;
  localparam int unsigned CNT_MAX   = (1 << TB_STAT_W) - 1;
`ifdef CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam logic [31:0] BUBBLE = 32'hFC000000;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int n_checks = 0;
  int n_errors = 0;

  pipelined_controller_if #(.REG_ADDR_W(5), .ALUOP_W(2), .STAT_W(TB_STAT_W)) bus ();

  pipelined_controller #(.REG_ADDR_W(5), .ALUOP_W(2), .STAT_W(TB_STAT_W)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       regdst, alusrc, branch;
    logic [1:0] aluop;
    logic       memread, memwrite, memtoreg, regwrite;
    logic [4:0] wr;
  } mdl_t;

  typedef struct {
    logic [31:0] ins;
    mdl_t        exp;
  } vec_t;

  // Reference decode written straight from the opcode rules.
  function automatic mdl_t mdec(input logic [31:0] w);
    mdl_t d = '0;
    case (w[31:26])
      6'h00: begin d.regdst = 1; d.aluop = 2'b10; d.regwrite = 1; end
      6'h23: begin d.alusrc = 1; d.memread = 1; d.memtoreg = 1; d.regwrite = 1; end
      6'h2B: begin d.alusrc = 1; d.memwrite = 1; end
      6'h04: begin d.branch = 1; d.aluop = 2'b01; end
      6'h08: begin d.alusrc = 1; d.regwrite = 1; end
      default: return '0;
    endcase
    d.wr = d.regdst ? w[15:11] : w[20:16];
    if (d.wr == 5'd0) d.regwrite = 0;
    return d;
  endfunction

  function automatic bit reads_rt(input logic [31:0] w);
    return (w[31:26] == 6'h00) || (w[31:26] == 6'h2B) || (w[31:26] == 6'h04);
  endfunction

  function automatic logic [31:0] ex_act();
    return 32'({bus.ExRegDst, bus.ExALUSrc, bus.ExBranch, bus.ExALUOp, bus.ExWriteReg});
  endfunction

  function automatic logic [31:0] ex_exp(input mdl_t d);
    return 32'({d.regdst, d.alusrc, d.branch, d.aluop, d.wr});
  endfunction

  function automatic logic [31:0] all_act();
    return 32'({bus.ExRegDst, bus.ExALUSrc, bus.ExBranch, bus.ExALUOp, bus.ExWriteReg,
                bus.MemMemRead, bus.MemMemWrite, bus.WbMemtoReg, bus.WbRegWrite,
                bus.WbWriteReg, bus.PCSrc, bus.PCWrite, bus.IfIdWrite, bus.IfIdFlush});
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
    #1;
  endtask

  task automatic set(input logic [31:0] ins, input logic z);
    bus.Instruction = ins;
    bus.Zero        = z;
    #1;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    set(32'h0, 1'b0);
    tick();
    tick();
    Rst = 1'b0;
  endtask

  vec_t tbl[8];

  initial begin
    mdl_t e, m, w;
    logic [31:0] ins, exp_all;
    logic z;
    logic [31:0] m_ex, m_mem, m_wb;
    int unsigned m_sc, m_fc;
    bit stall_m, taken, held;
    logic [5:0] ops [6];

    tbl[0] = '{32'h00221820, '{1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3}}; // add $3,$1,$2
    tbl[1] = '{32'h8C450004, '{1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5}}; // lw $5,4($2)
    tbl[2] = '{32'hAC660008, '{1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 5'd6}}; // sw $6,8($3)
    tbl[3] = '{32'h10220003, '{1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2}}; // beq $1,$2
    tbl[4] = '{32'h20270005, '{1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7}}; // addi $7,$1,5
    tbl[5] = '{32'h00000000, '{1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0}}; // sll nop
    tbl[6] = '{32'h00220020, '{1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0}}; // add $0,$1,$2
    tbl[7] = '{32'hFC221820, '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0}}; // unknown

    // Reset state.
    do_reset();
    chk("reset_all", all_act(), 32'h6);
    chk("reset_stallcnt", 32'(bus.StallCount), 32'h0);
    chk("reset_flushcnt", 32'(bus.FlushCount), 32'h0);

    // Decode table, observed at each stage.
    for (int i = 0; i < 8; i++) begin
      set(tbl[i].ins, 1'b0);
      tick();
      set(32'h0, 1'b0);
      chk($sformatf("tbl%0d_ex", i), ex_act(), ex_exp(tbl[i].exp));
      tick();
      chk($sformatf("tbl%0d_mem", i), 32'({bus.MemMemRead, bus.MemMemWrite}),
          32'({tbl[i].exp.memread, tbl[i].exp.memwrite}));
      tick();
      chk($sformatf("tbl%0d_wb", i), 32'({bus.WbMemtoReg, bus.WbRegWrite, bus.WbWriteReg}),
          32'({tbl[i].exp.memtoreg, tbl[i].exp.regwrite, tbl[i].exp.wr}));
      tick();
    end

    // Load-use: lw $1,0($0) then add $2,$1,$1.
    do_reset();
    set(32'h8C010000, 1'b0);
    tick();
    set(32'h00211020, 1'b0);
    chk("lu_stall_en", 32'({bus.PCWrite, bus.IfIdWrite}), 32'h0);
    tick();
    chk("lu_bubble", ex_act(), 32'h0);
    chk("lu_resume_en", 32'({bus.PCWrite, bus.IfIdWrite}), 32'h3);
    tick();
    set(32'h0, 1'b0);
    chk("lu_add_ex", ex_act(), 32'({1'b1, 1'b0, 1'b0, 2'b10, 5'd2}));
    chk("lu_stallcnt", 32'(bus.StallCount), PERF ? 32'd1 : 32'd0);

    // Taken branch, then not-taken branch.
    do_reset();
    set(32'h10220003, 1'b0);
    tick();
    set(32'h00221820, 1'b1);
    chk("br_taken", 32'({bus.PCSrc, bus.IfIdFlush, bus.PCWrite, bus.IfIdWrite}), 32'hF);
    tick();
    set(32'h0, 1'b0);
    chk("br_bubble", ex_act(), 32'h0);
    chk("br_flushcnt", 32'(bus.FlushCount), PERF ? 32'd1 : 32'd0);
    set(32'h10220003, 1'b0);
    tick();
    set(32'h00221820, 1'b0);
    chk("br_nottaken", 32'({bus.PCSrc, bus.IfIdFlush, bus.PCWrite, bus.IfIdWrite}), 32'h3);
    tick();
    set(32'h0, 1'b0);
    chk("br_nt_flow", ex_act(), 32'({1'b1, 1'b0, 1'b0, 2'b10, 5'd3}));
    chk("br_nt_flushcnt", 32'(bus.FlushCount), PERF ? 32'd1 : 32'd0);

    // Reset with lw/sw/add in flight.
    set(32'h8C450004, 1'b0);
    tick();
    set(32'hAC660008, 1'b0);
    tick();
    set(32'h00221820, 1'b0);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    set(32'h0, 1'b0);
    chk("midrst_all", all_act(), 32'h6);
    chk("midrst_cnt", 32'({bus.StallCount, bus.FlushCount}), 32'h0);
    set(32'h00221820, 1'b0);
    tick();
    set(32'h0, 1'b0);
    chk("midrst_add_ex", ex_act(), 32'({1'b1, 1'b0, 1'b0, 2'b10, 5'd3}));
    tick();
    tick();
    chk("midrst_add_wb", 32'({bus.WbMemtoReg, bus.WbRegWrite, bus.WbWriteReg}), 32'({1'b0, 1'b1, 5'd3}));

    // Drive 2^STAT_W + 3 load-use stalls to hit saturation.
    do_reset();
    for (int i = 0; i < int'(CNT_MAX) + 4; i++) begin
      set(32'h8C010000, 1'b0);
      tick();
      set(32'h00211020, 1'b0);
      tick();
      tick();
    end
    set(32'h0, 1'b0);
    chk("sat_stallcnt", 32'(bus.StallCount), PERF ? 32'(CNT_MAX) : 32'd0);

    // Randomized run against an instruction-level pipeline model.
    do_reset();
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h3F};
    m_ex = BUBBLE; m_mem = BUBBLE; m_wb = BUBBLE;
    m_sc = 0; m_fc = 0;
    held = 0;
    ins = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      if (!held)
        ins = {ops[$urandom_range(0, 5)], 3'b0, 2'($urandom_range(0, 3)), 3'b0,
               2'($urandom_range(0, 3)), 3'b0, 2'($urandom_range(0, 3)), 11'($urandom)};
      z = 1'($urandom_range(0, 1));
      set(ins, z);
      e = mdec(m_ex);
      m = mdec(m_mem);
      w = mdec(m_wb);
      taken   = e.branch && z;
      stall_m = e.memread && (e.wr != 0) &&
                ((e.wr == ins[25:21]) || (reads_rt(ins) && (e.wr == ins[20:16])));
      stall_m = stall_m && !taken;
      exp_all = 32'({e.regdst, e.alusrc, e.branch, e.aluop, e.wr,
                     m.memread, m.memwrite, w.memtoreg, w.regwrite, w.wr,
                     taken, !stall_m, !stall_m, taken});
      chk("rand_outputs", all_act(), exp_all);
      chk("rand_counters", 32'({bus.StallCount, bus.FlushCount}),
          PERF ? 32'({TB_STAT_W'(m_sc), TB_STAT_W'(m_fc)}) : 32'h0);
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ex  = (taken || stall_m) ? BUBBLE : ins;
      if (stall_m && m_sc < CNT_MAX) m_sc++;
      if (taken && m_fc < CNT_MAX) m_fc++;
      held = stall_m;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
